// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall pipeline controller.
//  - 2-bit state encodings and the FSM state type
//  - NOP_INSTR: the encoding that IF/ID holds after a flush
//  - REG_ZERO: hard-wired zero register, never a real dependency
package hazard_stall_unit_pkg;

    localparam logic [1:0] ST_RUN_ENC         = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL_ENC  = 2'd1;
    localparam logic [1:0] ST_MULDIV_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN         = ST_RUN_ENC,
        ST_LOAD_STALL  = ST_LOAD_STALL_ENC,
        ST_MULDIV_WAIT = ST_MULDIV_WAIT_ENC,
        ST_MEM_WAIT    = ST_MEM_WAIT_ENC
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'd0;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_hazard_compare.sv
// Combinational load-use comparator.
// A hazard exists when the instruction in EX is a load whose destination
// (other than the zero register) is read by the instruction in ID.
// Ports:
//  ifid_rs, ifid_rt   in  source registers of the ID instruction
//  ifid_uses_rt       in  ID instruction actually reads rt
//  idex_mem_read      in  EX instruction is a load
//  idex_dest_reg      in  destination register of the EX instruction
//  hazard             out load-use hazard present this cycle
module hazard_compare
    import hazard_stall_unit_pkg::*;
(
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_dest_reg,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (idex_dest_reg == ifid_rs);
        rt_match = ifid_uses_rt && (idex_dest_reg == ifid_rt);
        hazard   = idex_mem_read && (idex_dest_reg != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline-control FSM beside the ID stage. Drives PC write, IF/ID enable
// and flush, ID/EX enable and bubble, EX/MEM bubble. Outputs depend on the
// registered state and the current inputs, so they take effect in the same
// cycle, ahead of the IF/ID capture.
// Ports:
//  Clk, Reset_n           clock (posedge) and synchronous active-low reset
//  IFID_Rs/Rt/UsesRt      operands of the ID instruction
//  IDEX_MemRead/DestReg   load in EX and its destination
//  MulDivStart            first EX cycle of a mul/div
//  EXMEM_MemAcc/DMemReady data memory access in MEM and its completion
//  BranchTaken            taken branch/jump resolved in EX
//  PCWrite .. EXMEM_Bubble pipeline controls
//  ProtoErr               sticky: BranchTaken seen outside RUN
//  StallCycles            saturating count of cycles with PCWrite=0
//  dbg_state              current FSM state
// Handshake: none; every input is a level qualified by the current cycle and
// every output is a level acting on the same cycle's register captures.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULDIV_CYCLES     = 4,
    parameter int PERF_W            = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [4:0]        IFID_Rs,
    input  logic [4:0]        IFID_Rt,
    input  logic              IFID_UsesRt,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_DestReg,
    input  logic              MulDivStart,
    input  logic              EXMEM_MemAcc,
    input  logic              DMemReady,
    input  logic              BranchTaken,
    output logic              PCWrite,
    output logic              IFID_En,
    output logic              IFID_Flush,
    output logic              IDEX_En,
    output logic              IDEX_Bubble,
    output logic              EXMEM_Bubble,
    output logic              ProtoErr,
    output logic [PERF_W-1:0] StallCycles,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              proto_q, proto_d;
    logic [PERF_W-1:0] stall_q, stall_d;

    logic hazard;
    logic mem_stall;
    logic pc_write, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble;

    hazard_compare u_hazard_compare (
        .ifid_rs       (IFID_Rs),
        .ifid_rt       (IFID_Rt),
        .ifid_uses_rt  (IFID_UsesRt),
        .idex_mem_read (IDEX_MemRead),
        .idex_dest_reg (IDEX_DestReg),
        .hazard        (hazard)
    );

    assign mem_stall = EXMEM_MemAcc && !DMemReady;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        proto_d      = proto_q || (BranchTaken && (state_q != ST_RUN));
        pc_write     = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    pc_write     = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    ret_d        = ST_RUN;
                end else if (BranchTaken) begin
                    // The flushed ID instruction never reaches EX, so any
                    // hazard it would have caused is moot.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (MulDivStart) begin
                    pc_write     = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    if (MULDIV_CYCLES > 1) begin
                        state_d = ST_MULDIV_WAIT;
                        cnt_d   = 4'(MULDIV_CYCLES - 1);
                    end
                end else if (hazard) begin
                    pc_write    = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = ST_LOAD_STALL;
                        cnt_d   = 4'(LOAD_STALL_CYCLES - 1);
                    end
                end
            end
            ST_LOAD_STALL: begin
                pc_write = 1'b0;
                ifid_en  = 1'b0;
                if (mem_stall) begin
                    // Memory freeze wins; cnt holds so the remaining stall
                    // cycles are served after the freeze.
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    ret_d        = ST_LOAD_STALL;
                end else begin
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
            end
            ST_MULDIV_WAIT: begin
                pc_write     = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    ret_d   = ST_MULDIV_WAIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // The ready cycle itself still freezes; the data is only
                // consumed at this edge.
                pc_write     = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
                if (DMemReady) state_d = ret_q;
            end
            default: state_d = ST_RUN;
        endcase

        stall_d = stall_q;
        if (!pc_write && (stall_q != {PERF_W{1'b1}})) stall_d = stall_q + PERF_W'(1);

        PCWrite      = pc_write;
        IFID_En      = ifid_en;
        IFID_Flush   = ifid_flush;
        IDEX_En      = idex_en;
        IDEX_Bubble  = idex_bubble;
        EXMEM_Bubble = exmem_bubble;
        if (!Reset_n) begin
            PCWrite      = 1'b0;
            IFID_En      = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_En      = 1'b1;
            IDEX_Bubble  = 1'b1;
            EXMEM_Bubble = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            cnt_q   <= 4'd0;
            proto_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
            stall_q <= stall_d;
        end
    end

    assign ProtoErr    = proto_q;
    assign StallCycles = stall_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    // Output vector order: {PCWrite, IFID_En, IFID_Flush, IDEX_En, IDEX_Bubble, EXMEM_Bubble}
    localparam logic [5:0] O_RUN = 6'b110100;
    localparam logic [5:0] O_FRZ = 6'b000001;
    localparam logic [5:0] O_BR  = 6'b111110;
    localparam logic [5:0] O_LD  = 6'b000110;
    localparam logic [5:0] O_RST = 6'b001111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] ifid_rs, ifid_rt, idex_dest_reg;
    logic ifid_uses_rt, idex_mem_read, muldiv_start, exmem_mem_acc, dmem_ready, branch_taken;

    logic pc_write, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, proto_err;
    logic [15:0] stall_cycles;
    state_e dbg_state;

    logic pc_write3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_bubble3, proto_err3;
    logic [2:0] stall_cycles3;
    state_e dbg_state3;

    hazard_stall_unit dut (
        .Clk(clk), .Reset_n(rst_n), .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt),
        .IFID_UsesRt(ifid_uses_rt), .IDEX_MemRead(idex_mem_read), .IDEX_DestReg(idex_dest_reg),
        .MulDivStart(muldiv_start), .EXMEM_MemAcc(exmem_mem_acc), .DMemReady(dmem_ready),
        .BranchTaken(branch_taken), .PCWrite(pc_write), .IFID_En(ifid_en), .IFID_Flush(ifid_flush),
        .IDEX_En(idex_en), .IDEX_Bubble(idex_bubble), .EXMEM_Bubble(exmem_bubble),
        .ProtoErr(proto_err), .StallCycles(stall_cycles), .dbg_state(dbg_state)
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .MULDIV_CYCLES(4), .PERF_W(3)) dut3 (
        .Clk(clk), .Reset_n(rst_n), .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt),
        .IFID_UsesRt(ifid_uses_rt), .IDEX_MemRead(idex_mem_read), .IDEX_DestReg(idex_dest_reg),
        .MulDivStart(muldiv_start), .EXMEM_MemAcc(exmem_mem_acc), .DMemReady(dmem_ready),
        .BranchTaken(branch_taken), .PCWrite(pc_write3), .IFID_En(ifid_en3), .IFID_Flush(ifid_flush3),
        .IDEX_En(idex_en3), .IDEX_Bubble(idex_bubble3), .EXMEM_Bubble(exmem_bubble3),
        .ProtoErr(proto_err3), .StallCycles(stall_cycles3), .dbg_state(dbg_state3)
    );

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int exp_st  = 0;   // expected StallCycles of dut (16-bit, never near saturation here)
    int exp_st3 = 0;   // expected StallCycles of dut3 (3-bit, saturates at 7)

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_in();
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
        idex_mem_read = 1'b0; idex_dest_reg = 5'd0; muldiv_start = 1'b0;
        exmem_mem_acc = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b0;
    endtask

    task automatic load_hazard(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt);
        idex_mem_read = 1'b1; idex_dest_reg = rd; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = uses_rt;
    endtask

    // Called at a negedge with inputs already applied. Pushes the expected
    // control vector, samples one unit before the next posedge, pops and
    // compares, then advances to the following negedge.
    task automatic step(input string tag, input logic [5:0] expv, input bit use3);
        logic [5:0] obs;
        logic [5:0] e;
        exp_q.push_back(expv);
        #4;
        if (use3) obs = {pc_write3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_bubble3};
        else      obs = {pc_write, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble};
        e = exp_q.pop_front();
        chk(tag, 16'(obs), 16'(e));
        if (!rst_n) begin
            exp_st = 0; exp_st3 = 0;
        end else if (!e[5]) begin
            if (use3) begin
                if (exp_st3 < 7) exp_st3++;
            end else begin
                exp_st++;
            end
        end
        @(negedge clk);
    endtask

    function automatic bit model_hazard(input logic rd_ld, input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic uses);
        return rd_ld && (rd != 5'd0) && ((rd == rs) || (uses && (rd == rt)));
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle_in();
        @(negedge clk);

        // Reset behaviour
        step("rst_cyc0", O_RST, 0);
        step("rst_cyc1", O_RST, 0);
        chk("rst_stall", stall_cycles, 16'd0);
        chk("rst_proto", 16'(proto_err), 16'd0);
        rst_n = 1'b1;
        step("run_after_rst", O_RUN, 0);
        chk("stall_after_rst", stall_cycles, 16'd0);

        // Single-cycle load-use stall on Rs
        load_hazard(5'd8, 5'd8, 5'd0, 1'b0);
        step("ld_rs_stall", O_LD, 0);
        idle_in();
        step("ld_rs_resume", O_RUN, 0);
        chk("ld_stall_cnt", stall_cycles, 16'(exp_st));

        // No stall: zero register, or Rt match not used
        load_hazard(5'd0, 5'd0, 5'd0, 1'b1);
        step("ld_r0_nostall", O_RUN, 0);
        load_hazard(5'd9, 5'd3, 5'd9, 1'b0);
        step("ld_rt_unused", O_RUN, 0);
        ifid_uses_rt = 1'b1;
        step("ld_rt_used", O_LD, 0);
        idle_in();
        step("ld_rt_resume", O_RUN, 0);

        // Random register combinations against the comparator model
        for (int i = 0; i < 10; i++) begin
            logic [4:0] rd, rs, rt;
            logic ld, us;
            ld = 1'($urandom_range(0, 1));
            us = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            load_hazard(rd, rs, rt, us);
            idex_mem_read = ld;
            if (model_hazard(ld, rd, rs, rt, us)) begin
                step("rand_hz", O_LD, 0);
                idle_in();
                step("rand_hz_resume", O_RUN, 0);
            end else begin
                step("rand_nohz", O_RUN, 0);
            end
        end
        chk("rand_stall_cnt", stall_cycles, 16'(exp_st));

        // Mul/div: 4 hold cycles, branch in cycle 2 ignored and flagged
        idle_in();
        muldiv_start = 1'b1;
        step("md_c1", O_FRZ, 0);
        muldiv_start = 1'b0; branch_taken = 1'b1;
        step("md_c2_branch", O_FRZ, 0);
        branch_taken = 1'b0;
        step("md_c3", O_FRZ, 0);
        step("md_c4", O_FRZ, 0);
        step("md_c5_run", O_RUN, 0);
        chk("md_proto", 16'(proto_err), 16'd1);
        chk("md_stall_cnt", stall_cycles, 16'(exp_st));

        // Branch together with a hazard: flush wins, no stall afterwards
        load_hazard(5'd8, 5'd8, 5'd0, 1'b0);
        branch_taken = 1'b1;
        step("br_hz_flush", O_BR, 0);
        idle_in();
        step("br_hz_next", O_RUN, 0);

        // Memory wait from RUN, branch during freeze is ignored
        exmem_mem_acc = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        step("mem_c1", O_FRZ, 0);
        branch_taken = 1'b0;
        step("mem_c2", O_FRZ, 0);
        dmem_ready = 1'b1;
        step("mem_exit", O_FRZ, 0);
        idle_in();
        step("mem_resume", O_RUN, 0);
        chk("mem_stall_cnt", stall_cycles, 16'(exp_st));

        // Three-cycle load stall interrupted by a memory wait (dut3)
        rst_n = 1'b0;
        step("rst3", O_RST, 1);
        rst_n = 1'b1;
        chk("rst3_stall", 16'(stall_cycles3), 16'd0);
        load_hazard(5'd8, 5'd8, 5'd0, 1'b0);
        step("ls3_c1", O_LD, 1);
        idle_in();
        exmem_mem_acc = 1'b1; dmem_ready = 1'b0;
        step("ls3_frz1", O_FRZ, 1);
        step("ls3_frz2", O_FRZ, 1);
        dmem_ready = 1'b1;
        step("ls3_frz_exit", O_FRZ, 1);
        idle_in();
        step("ls3_c2", O_LD, 1);
        step("ls3_c3", O_LD, 1);
        step("ls3_run", O_RUN, 1);
        chk("ls3_stall_total", 16'(stall_cycles3), 16'(exp_st3));
        chk("ls3_stall_six", 16'(stall_cycles3), 16'd6);

        // Saturation, then reset mid-stall
        load_hazard(5'd4, 5'd4, 5'd0, 1'b0);
        step("sat_c1", O_LD, 1);
        idle_in();
        step("sat_c2", O_LD, 1);
        chk("sat_hold", 16'(stall_cycles3), 16'(exp_st3));
        rst_n = 1'b0;
        step("mid_rst", O_RST, 1);
        rst_n = 1'b1;
        step("mid_rst_run", O_RUN, 1);
        chk("mid_rst_stall", 16'(stall_cycles3), 16'd0);
        chk("mid_rst_state", 16'(dbg_state3), 16'(ST_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
